// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared types and helpers for the 4-channel stream arbiter family.
//   NUM_CH   - channel count (fixed at 4)
//   ch_idx_t - channel index type
//   rr_pick  - round-robin one-hot grant, search starts after ptr and wraps
//   oh2idx   - one-hot to index encode (zero-vector returns 0)
package stream_arb_pkg;
  localparam int NUM_CH = 4;
  typedef logic [1:0] ch_idx_t;

  function automatic logic [NUM_CH-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                                input ch_idx_t           ptr);
    logic [NUM_CH-1:0] gnt;
    ch_idx_t           idx;
    logic              found;
    gnt   = '0;
    found = 1'b0;
    // i = 1..4 visits ptr+1 .. ptr+4 (mod 4); the 2-bit add does the wrap.
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = ptr + ch_idx_t'(i);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  function automatic ch_idx_t oh2idx(input logic [NUM_CH-1:0] oh);
    ch_idx_t idx;
    idx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (oh[i]) idx = ch_idx_t'(i);
    return idx;
  endfunction
endpackage

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: 4-way round-robin arbiter with last-granted pointer.
//   clk_i, rst_ni - clock, async active-low reset
//   req_i         - request vector
//   accept_i      - strobe: current grant was taken, advance pointer to it
//   gnt_o         - one-hot grant (combinational)
//   gnt_idx_o     - index of granted channel (valid when gnt_o != 0)
module rr_arbiter_4
  import stream_arb_pkg::*;
#(
  parameter ch_idx_t PTR_RST = 2'd3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              accept_i,
  output logic [NUM_CH-1:0] gnt_o,
  output ch_idx_t           gnt_idx_o
);

  ch_idx_t ptr_q;

  assign gnt_o     = rr_pick(req_i, ptr_q);
  assign gnt_idx_o = oh2idx(gnt_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       ptr_q <= PTR_RST;
    else if (accept_i) ptr_q <= gnt_idx_o;
  end

endmodule

// File: rtl/stream_arb_mux_4x1.sv
// stream_arb_mux_4x1: merges four valid/ready source streams into one
// registered output stream with round-robin arbitration, full throughput.
//   clk_i, rst_ni - clock, async active-low reset
//   valid_i/data_i/ready_o - four source channels (ready_o combinational, one-hot0)
//   valid_o/data_o/sel_o   - registered output beat and its source index
//   ready_i                - downstream accept
// Optional macro STREAM_ARB_MUX_PKT_LOCK_EN adds last_i[3:0] / last_o and
// holds the grant on one channel until its packet's last beat transfers.
module stream_arb_mux_4x1
  import stream_arb_pkg::*;
#(
  parameter int      N       = 3,
  parameter ch_idx_t PTR_RST = 2'd3
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_CH-1:0]      valid_i,
  input  logic [NUM_CH-1:0][N:0] data_i,
  output logic [NUM_CH-1:0]      ready_o,
`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
  input  logic [NUM_CH-1:0]      last_i,
  output logic                   last_o,
`endif
  output logic                   valid_o,
  output logic [N:0]             data_o,
  output ch_idx_t                sel_o,
  input  logic                   ready_i
);

  logic              load;
  logic [NUM_CH-1:0] req, gnt, lock_mask;
  ch_idx_t           gnt_idx;
  logic              xfer;

  // Output register can take a new beat if empty or draining this cycle.
  assign load = !valid_o || ready_i;

`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
  logic    lock_q;
  ch_idx_t lock_ch_q;

  assign lock_mask = lock_q ? (NUM_CH'(1) << lock_ch_q) : '1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else if (xfer) begin
      lock_q    <= !last_i[gnt_idx];
      lock_ch_q <= gnt_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   last_o <= 1'b0;
    else if (xfer) last_o <= last_i[gnt_idx];
  end
`else
  assign lock_mask = '1;
`endif

  assign req     = valid_i & {NUM_CH{load}} & lock_mask;
  assign ready_o = gnt;
  assign xfer    = |gnt;

  rr_arbiter_4 #(.PTR_RST(PTR_RST)) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req),
    .accept_i  (xfer),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      sel_o   <= '0;
    end else if (xfer) begin
      valid_o <= 1'b1;
      data_o  <= data_i[gnt_idx];
      sel_o   <= gnt_idx;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(ready_o));
  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> (valid_o && $stable(data_o) && $stable(sel_o)));
`endif

endmodule
